// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive core.
//   DATA_W      - data bits per frame (default for the core and bus interface)
//   FIFO_DEPTH  - receive FIFO entries (power of two, at least 2)
//   CLKDIV_MIN  - smallest usable cycles-per-bit; smaller clkdiv values clamp here
//   rx_state_e  - receiver FSM states
//   eff_div()   - clamps a requested clkdiv to CLKDIV_MIN
package uart_pkg;

  localparam int          DATA_W     = 8;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [15:0] CLKDIV_MIN = 16'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div < CLKDIV_MIN) ? CLKDIV_MIN : div;
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: host-side bus of the UART receiver.
//   rd_en     host -> core  pop the FIFO head
//   irq_clr   host -> core  clear the "byte received" interrupt
//   err_clr   host -> core  clear frame_err and overrun
//   rx_data   core -> host  FIFO head byte
//   rx_valid  core -> host  FIFO non-empty
//   irq       core -> host  level interrupt
//   frame_err core -> host  sticky framing error
//   overrun   core -> host  sticky overrun
// modport master is the host side, modport slave is the receiver core.
interface uart_rx_core_if #(
  parameter int DATA_W = uart_pkg::DATA_W
);

  logic              rd_en;
  logic              irq_clr;
  logic              err_clr;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              irq;
  logic              frame_err;
  logic              overrun;

  modport master (
    output rd_en, irq_clr, err_clr,
    input  rx_data, rx_valid, irq, frame_err, overrun
  );

  modport slave (
    input  rd_en, irq_clr, err_clr,
    output rx_data, rx_valid, irq, frame_err, overrun
  );

endinterface

// File: rtl/uart_rx_core_fifo.sv
// uart_rx_fifo: small receive FIFO.
//   clock, resetb  clock and asynchronous active-low reset
//   push, push_data write request and data
//   pop            read request (ignored while empty)
//   rd_data        head entry, zero while empty
//   full, empty    status
//   count          number of stored entries
// A push while full is dropped unless a pop happens in the same cycle,
// in which case both take effect and the count is unchanged.
module uart_rx_fifo #(
  parameter int DEPTH = uart_pkg::FIFO_DEPTH,
  parameter int W     = uart_pkg::DATA_W
) (
  input  logic                     clock,
  input  logic                     resetb,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_ok, rd_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A pop frees the slot the simultaneous push needs, so full+pop still writes.
  assign wr_ok = push && (!full || pop);
  assign rd_ok = pop && !empty;

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr_q] <= push_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with receive FIFO, interrupt and error flags.
//   clock   sole clock, rising edge
//   resetb  asynchronous active-low reset
//   clkdiv  clock cycles per bit (values below CLKDIV_MIN act as CLKDIV_MIN)
//   rx      serial input, idle high, LSB first
//   bus     host bus (slave modport): rd_en/irq_clr/err_clr in,
//           rx_data/rx_valid/irq/frame_err/overrun out
// The divider is latched at the start-bit edge so that clkdiv changes only
// take effect for the next frame. Start is verified at half a bit, after
// which every sample falls one full bit later (mid-bit).
module uart_rx_core #(
  parameter int FIFO_DEPTH = uart_pkg::FIFO_DEPTH,
  parameter int DATA_W     = uart_pkg::DATA_W
) (
  input  logic          clock,
  input  logic          resetb,
  input  logic [15:0]   clkdiv,
  input  logic          rx,
  uart_rx_core_if.slave bus
);

  import uart_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W);

  // ---------------- input synchronizer (preset to idle level) ----------
  logic [1:0] sync_q, sync_d;
  logic       rx_s;

  assign sync_d = {sync_q[0], rx};
  assign rx_s   = sync_q[1];

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) sync_q <= 2'b11;
    else         sync_q <= sync_d;
  end

  // ---------------- receiver FSM -----------------------------------------
  rx_state_e         state_q;
  logic [15:0]       cnt_q;
  logic [15:0]       div_q;
  logic [BW-1:0]     bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              push_q;     // one-cycle request: good byte in shift_q
  logic              ferr_q;     // one-cycle request: stop bit was low
  logic [15:0]       div_eff;
  logic              tick;

  assign div_eff = eff_div(clkdiv);
  // Counter expires on the cycle it would reach zero.
  assign tick    = (cnt_q <= 16'd1);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            div_q   <= div_eff;
            cnt_q   <= div_eff >> 1;
            bit_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            if (rx_s) begin
              // Line went back high before mid-start: a glitch, not a frame.
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q   <= div_q;
              state_q <= DATA;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        DATA: begin
          if (tick) begin
            shift_q <= {rx_s, shift_q[DATA_W-1:1]};
            cnt_q   <= div_q;
            if (bit_q == BW'(DATA_W - 1)) begin
              bit_q   <= '0;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        STOP: begin
          if (tick) begin
            cnt_q   <= '0;
            push_q  <= rx_s;
            ferr_q  <= !rx_s;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------- receive FIFO ------------------------------------------
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_full, fifo_empty;
  logic [AW:0]       fifo_count;
  logic              push_ok, push_drop;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clock     (clock),
    .resetb    (resetb),
    .push      (push_q),
    .push_data (shift_q),
    .pop       (bus.rd_en),
    .rd_data   (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Mirrors the FIFO's acceptance rule: a full FIFO still takes the byte
  // when a pop of a (necessarily non-empty) head happens in the same cycle.
  assign push_ok   = push_q && (!fifo_full || (bus.rd_en && !fifo_empty));
  assign push_drop = push_q && !push_ok;

  assign bus.rx_data  = fifo_rd_data;
  assign bus.rx_valid = (fifo_count != '0);

  // ---------------- interrupt and sticky flags (set beats clear) -----------
  logic irq_q, irq_d;
  logic frame_err_q, frame_err_d;
  logic overrun_q, overrun_d;

  always_comb begin
    irq_d       = irq_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (bus.irq_clr) irq_d = 1'b0;
    if (push_ok)     irq_d = 1'b1;
    if (bus.err_clr) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (ferr_q)    frame_err_d = 1'b1;
    if (push_drop) overrun_d   = 1'b1;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      irq_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      irq_q       <= irq_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.irq       = irq_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed bench for uart_rx_core.
// A table of frames (data, stop level, divider) with hand-computed results
// is replayed in a loop; the multi-cycle corner cases (latency, glitch,
// overrun, full push+pop, divider change, mid-frame reset) are written out.
// Inputs change on the falling clock edge; outputs are read there too.
module tb_uart_rx_core;

  import uart_pkg::*;

  logic        clock  = 1'b0;
  logic        resetb = 1'b0;
  logic [15:0] clkdiv = 16'd16;
  logic        rx     = 1'b1;

  uart_rx_core_if #(.DATA_W(8)) bus ();

  uart_rx_core #(
    .FIFO_DEPTH (4),
    .DATA_W     (8)
  ) dut (
    .clock  (clock),
    .resetb (resetb),
    .clkdiv (clkdiv),
    .rx     (rx),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic [15:0] div;
    int          bit_len;    // line bit period in cycles (clamped divider)
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_ferr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Drive one frame with bit period d, followed by two idle bit periods.
  // pop_at/rst_at/chg_at are cycle indices within the frame (-1 = unused).
  // seen returns the cycle index at which rx_valid was first observed high.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int d,
                            input int pop_at, input int rst_at,
                            input int chg_at, input logic [15:0] chg_val,
                            output int seen);
    seen = -1;
    for (int j = 0; j < 12 * d; j++) begin
      int b;
      b = j / d;
      if (b == 0)      rx = 1'b0;
      else if (b <= 8) rx = data[b-1];
      else if (b == 9) rx = stop;
      else             rx = 1'b1;
      bus.rd_en = (j == pop_at);
      if (j == rst_at)     resetb = 1'b0;
      if (j == rst_at + 2) resetb = 1'b1;
      if (j == chg_at)     clkdiv = chg_val;
      @(negedge clock);
      if (seen < 0 && bus.rx_valid) seen = j + 1;
    end
    bus.rd_en = 1'b0;
    rx        = 1'b1;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check({name, "_valid"}, 32'(bus.rx_valid), 32'd1);
    check({name, "_data"}, 32'(bus.rx_data), 32'(exp));
    bus.rd_en = 1'b1;
    @(negedge clock);
    bus.rd_en = 1'b0;
  endtask

  task automatic pulse_irq_clr();
    bus.irq_clr = 1'b1;
    @(negedge clock);
    bus.irq_clr = 1'b0;
  endtask

  task automatic pulse_err_clr();
    bus.err_clr = 1'b1;
    @(negedge clock);
    bus.err_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;

    //            data   stop  div    len valid  exp    ferr
    vecs[0] = '{8'hA5, 1'b1, 16'd16, 16, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 16'd8,   8, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 16'd5,   5, 1'b1, 8'hFF, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 16'd4,   4, 1'b1, 8'h80, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 16'd2,   4, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'hC3, 1'b1, 16'd0,   4, 1'b1, 8'hC3, 1'b0};
    vecs[6] = '{8'h7E, 1'b0, 16'd8,   8, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{8'h5A, 1'b1, 16'd33, 33, 1'b1, 8'h5A, 1'b0};

    bus.rd_en   = 1'b0;
    bus.irq_clr = 1'b0;
    bus.err_clr = 1'b0;

    // ---- reset state ----
    repeat (3) @(negedge clock);
    check("rst_rx_valid",  32'(bus.rx_valid),  32'd0);
    check("rst_rx_data",   32'(bus.rx_data),   32'd0);
    check("rst_irq",       32'(bus.irq),       32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_overrun",   32'(bus.overrun),   32'd0);
    check("rst_sync",      32'(dut.sync_q),    32'd3);
    check("rst_state",     32'(dut.state_q),   32'(IDLE));
    resetb = 1'b1;
    repeat (2) @(negedge clock);

    // ---- 0x3D at clkdiv=16: stop sampled 2 sync cycles + 8 + 9*16 after the
    // start edge (cycle 154); rx_valid is visible from the next cycle, so it
    // is first seen at index 156.
    clkdiv = 16'd16;
    send_frame(8'h3D, 1'b1, 16, -1, -1, -1, 16'd0, seen);
    check("lat_first_valid", 32'(seen), 32'd156);
    check("lat_irq",         32'(bus.irq), 32'd1);
    check("lat_data",        32'(bus.rx_data), 32'h3D);
    pulse_irq_clr();
    check("irq_clr_irq",     32'(bus.irq), 32'd0);
    pop_check("pop_3d", 8'h3D);
    check("pop_3d_empty",    32'(bus.rx_valid), 32'd0);

    // ---- 5-cycle glitch ----
    rx = 1'b0;
    repeat (5) @(negedge clock);
    rx = 1'b1;
    repeat (40) @(negedge clock);
    check("glitch_valid",     32'(bus.rx_valid),  32'd0);
    check("glitch_frame_err", 32'(bus.frame_err), 32'd0);
    check("glitch_state",     32'(dut.state_q),   32'(IDLE));

    // ---- 0x55 with stop bit low ----
    send_frame(8'h55, 1'b0, 16, -1, -1, -1, 16'd0, seen);
    check("ferr_valid",     32'(bus.rx_valid),  32'd0);
    check("ferr_frame_err", 32'(bus.frame_err), 32'd1);
    check("ferr_irq",       32'(bus.irq),       32'd0);
    pulse_err_clr();
    check("ferr_cleared",   32'(bus.frame_err), 32'd0);

    // ---- table of frames ----
    foreach (vecs[i]) begin
      clkdiv = vecs[i].div;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].bit_len, -1, -1, -1, 16'd0, seen);
      check($sformatf("vec%0d_valid", i), 32'(bus.rx_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_data", i), 32'(bus.rx_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_frame_err", i), 32'(bus.frame_err), 32'(vecs[i].exp_ferr));
      bus.rd_en = 1'b1;
      pulse_err_clr();
      bus.rd_en = 1'b0;
      pulse_irq_clr();
    end
    clkdiv = 16'd16;

    // ---- five bytes, no reads: fifth is dropped ----
    for (int k = 1; k <= 5; k++)
      send_frame(8'(k), 1'b1, 16, -1, -1, -1, 16'd0, seen);
    check("ovr_overrun", 32'(bus.overrun), 32'd1);
    for (int k = 1; k <= 4; k++)
      pop_check($sformatf("ovr_pop%0d", k), 8'(k));
    check("ovr_drained", 32'(bus.rx_valid), 32'd0);
    pulse_err_clr();
    check("ovr_cleared", 32'(bus.overrun), 32'd0);

    // ---- full FIFO, pop coincides with push of 0xA5 (push request is
    // live between cycles 154 and 155, so rd_en is driven at index 155) ----
    send_frame(8'h11, 1'b1, 16, -1, -1, -1, 16'd0, seen);
    send_frame(8'h22, 1'b1, 16, -1, -1, -1, 16'd0, seen);
    send_frame(8'h33, 1'b1, 16, -1, -1, -1, 16'd0, seen);
    send_frame(8'h44, 1'b1, 16, -1, -1, -1, 16'd0, seen);
    send_frame(8'hA5, 1'b1, 16, 155, -1, -1, 16'd0, seen);
    check("full_pp_overrun", 32'(bus.overrun), 32'd0);
    pop_check("full_pp_pop1", 8'h22);
    pop_check("full_pp_pop2", 8'h33);
    pop_check("full_pp_pop3", 8'h44);
    pop_check("full_pp_pop4", 8'hA5);
    check("full_pp_drained", 32'(bus.rx_valid), 32'd0);

    // ---- clkdiv changed mid-frame: frame still uses the latched 16 ----
    send_frame(8'h96, 1'b1, 16, -1, -1, 50, 16'd6, seen);
    pop_check("div_chg", 8'h96);
    clkdiv = 16'd16;

    // ---- reset during DATA of 0xFF, then a clean 0x12 ----
    pulse_irq_clr();
    send_frame(8'hFF, 1'b1, 16, -1, 40, -1, 16'd0, seen);
    check("rstmid_valid", 32'(bus.rx_valid),  32'd0);
    check("rstmid_ferr",  32'(bus.frame_err), 32'd0);
    check("rstmid_irq",   32'(bus.irq),       32'd0);
    send_frame(8'h12, 1'b1, 16, -1, -1, -1, 16'd0, seen);
    check("rstmid_ferr2", 32'(bus.frame_err), 32'd0);
    check("rstmid_ovr2",  32'(bus.overrun),   32'd0);
    pop_check("rstmid_pop", 8'h12);
    check("rstmid_drained", 32'(bus.rx_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
